// File: rtl/ldpc_pkg.sv
// Shared sizing constants and scheduler state encoding for the flooding LDPC decoder.
// Also imported by the vr/check top-level so both sides agree on node counts and widths.
package ldpc_pkg;

  localparam int unsigned LDPC_N_VN  = 16;
  localparam int unsigned LDPC_N_CN  = 8;
  localparam int unsigned LDPC_VN_AW = 4;
  localparam int unsigned LDPC_CN_AW = 3;
  localparam int unsigned LDPC_IT_W  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_VN    = 3'd2,
    ST_CN    = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } ldpc_state_e;

endpackage

// File: rtl/ldpc_idx_counter.sv
// Modulo-N node index counter with synchronous clear and a last-index flag.
// Exposes the next index so the owner can register address outputs without an extra cycle.
module ldpc_idx_counter #(
  parameter int unsigned N  = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] idx_nxt,
  output logic          last
);

  logic [AW-1:0] idx_q;
  logic [AW-1:0] idx_d;

  assign last = (idx_q == AW'(N - 1));

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = last ? '0 : idx_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_nxt = idx_d;

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// Iteration scheduler: channel-LLR load, then alternating vr / check sweeps until
// every check is satisfied or the iteration cap is reached.
module ldpc_iter_ctrl
  import ldpc_pkg::*;
#(
  parameter int unsigned N_VN  = LDPC_N_VN,
  parameter int unsigned N_CN  = LDPC_N_CN,
  parameter int unsigned VN_AW = LDPC_VN_AW,
  parameter int unsigned CN_AW = LDPC_CN_AW,
  parameter int unsigned IT_W  = LDPC_IT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [IT_W-1:0]  max_iter,
  input  logic             ch_valid,
  output logic             ch_ready,
  output logic [VN_AW-1:0] ch_addr,
  output logic             vn_en,
  output logic [VN_AW-1:0] vn_addr,
  output logic             cn_en,
  output logic [CN_AW-1:0] cn_addr,
  input  logic             synd_bit,
  output logic             busy,
  output logic             done,
  output logic             converged,
  output logic [IT_W-1:0]  iter_cnt
);

  ldpc_state_e state_q, state_d;

  logic [IT_W-1:0]  cap_q, cap_d;
  logic [IT_W-1:0]  iter_q, iter_d;
  logic             conv_q, conv_d;
  logic             synd_or_q, synd_or_d;

  logic             ch_ready_q, ch_ready_d;
  logic [VN_AW-1:0] ch_addr_q, ch_addr_d;
  logic             vn_en_q, vn_en_d;
  logic [VN_AW-1:0] vn_addr_q, vn_addr_d;
  logic             cn_en_q, cn_en_d;
  logic [CN_AW-1:0] cn_addr_q, cn_addr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             vn_clr, vn_step, vn_last;
  logic [VN_AW-1:0] vn_idx_nxt;
  logic             cn_clr, cn_step, cn_last;
  logic [CN_AW-1:0] cn_idx_nxt;

  // One counter walks both the LLR load and the vr sweep; they never overlap.
  ldpc_idx_counter #(
    .N  (N_VN),
    .AW (VN_AW)
  ) u_vn_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (vn_clr),
    .en      (vn_step),
    .idx_nxt (vn_idx_nxt),
    .last    (vn_last)
  );

  ldpc_idx_counter #(
    .N  (N_CN),
    .AW (CN_AW)
  ) u_cn_idx (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cn_clr),
    .en      (cn_step),
    .idx_nxt (cn_idx_nxt),
    .last    (cn_last)
  );

  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    iter_d    = iter_q;
    conv_d    = conv_q;
    synd_or_d = synd_or_q;
    vn_clr    = 1'b0;
    vn_step   = 1'b0;
    cn_clr    = 1'b0;
    cn_step   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        vn_clr = 1'b1;
        cn_clr = 1'b1;
        if (start) begin
          state_d = ST_LOAD;
          cap_d   = (max_iter == '0) ? IT_W'(1) : max_iter;
          iter_d  = '0;
          conv_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ch_valid) begin
          vn_step = 1'b1;
          if (vn_last) begin
            state_d = ST_VN;
          end
        end
      end
      ST_VN: begin
        vn_step = 1'b1;
        if (vn_last) begin
          state_d   = ST_CN;
          synd_or_d = 1'b0;
        end
      end
      ST_CN: begin
        cn_step   = 1'b1;
        synd_or_d = synd_or_q | synd_bit;
        if (cn_last) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        iter_d = (iter_q == '1) ? iter_q : iter_q + IT_W'(1);
        if (!synd_or_q) begin
          conv_d  = 1'b1;
          state_d = ST_DONE;
        end else if ((iter_q + IT_W'(1)) == cap_q) begin
          conv_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          state_d = ST_VN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and next index so they leave flops.
  always_comb begin
    ch_ready_d = (state_d == ST_LOAD);
    ch_addr_d  = ch_ready_d ? vn_idx_nxt : '0;
    vn_en_d    = (state_d == ST_VN);
    vn_addr_d  = vn_en_d ? vn_idx_nxt : '0;
    cn_en_d    = (state_d == ST_CN);
    cn_addr_d  = cn_en_d ? cn_idx_nxt : '0;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cap_q      <= '0;
      iter_q     <= '0;
      conv_q     <= 1'b0;
      synd_or_q  <= 1'b0;
      ch_ready_q <= 1'b0;
      ch_addr_q  <= '0;
      vn_en_q    <= 1'b0;
      vn_addr_q  <= '0;
      cn_en_q    <= 1'b0;
      cn_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      iter_q     <= iter_d;
      conv_q     <= conv_d;
      synd_or_q  <= synd_or_d;
      ch_ready_q <= ch_ready_d;
      ch_addr_q  <= ch_addr_d;
      vn_en_q    <= vn_en_d;
      vn_addr_q  <= vn_addr_d;
      cn_en_q    <= cn_en_d;
      cn_addr_q  <= cn_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign ch_ready  = ch_ready_q;
  assign ch_addr   = ch_addr_q;
  assign vn_en     = vn_en_q;
  assign vn_addr   = vn_addr_q;
  assign cn_en     = cn_en_q;
  assign cn_addr   = cn_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = conv_q;
  assign iter_cnt  = iter_q;

  a_enables_exclusive: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0({ch_ready_q, vn_en_q, cn_en_q})
  );

endmodule

// File: tb/tb_ldpc_iter_ctrl.sv
// Randomized decode requests scored against an iteration-level model of the scheduler;
// a monitor pops expected results when done pulses and checks address sequencing.
module tb_ldpc_iter_ctrl;

  localparam int unsigned N_VN  = 16;
  localparam int unsigned N_CN  = 8;
  localparam int unsigned VN_AW = 4;
  localparam int unsigned CN_AW = 3;
  localparam int unsigned IT_W  = 4;
  localparam int          WDOG  = 600;

  logic             clk      = 1'b0;
  logic             rst_n    = 1'b0;
  logic             start    = 1'b0;
  logic [IT_W-1:0]  max_iter = '0;
  logic             ch_valid = 1'b0;
  logic             synd_bit = 1'b0;
  logic             ch_ready, vn_en, cn_en, busy, done, converged;
  logic [VN_AW-1:0] ch_addr, vn_addr;
  logic [CN_AW-1:0] cn_addr;
  logic [IT_W-1:0]  iter_cnt;

  ldpc_iter_ctrl #(
    .N_VN  (N_VN),
    .N_CN  (N_CN),
    .VN_AW (VN_AW),
    .CN_AW (CN_AW),
    .IT_W  (IT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .max_iter  (max_iter),
    .ch_valid  (ch_valid),
    .ch_ready  (ch_ready),
    .ch_addr   (ch_addr),
    .vn_en     (vn_en),
    .vn_addr   (vn_addr),
    .cn_en     (cn_en),
    .cn_addr   (cn_addr),
    .synd_bit  (synd_bit),
    .busy      (busy),
    .done      (done),
    .converged (converged),
    .iter_cnt  (iter_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit conv;
    int iters;
    int lat;
    int vn;
    int cn;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Per-iteration failing-check masks and per-beat idle gaps for the current decode.
  logic [N_CN-1:0] masks [16];
  int              gaps  [N_VN];

  // A decode runs until the first iteration whose checks all pass, or the cap.
  function automatic exp_t model(input int mi, input int gap_total);
    exp_t r;
    int   cap;
    cap    = (mi == 0) ? 1 : mi;
    r.conv = 1'b0;
    r.iters = cap;
    for (int i = 0; i < cap; i++) begin
      if (masks[i] == '0) begin
        r.conv  = 1'b1;
        r.iters = i + 1;
        break;
      end
    end
    r.lat = N_VN + gap_total + r.iters * (N_VN + N_CN + 1) + 1;
    r.vn  = r.iters * N_VN;
    r.cn  = r.iters * N_CN;
    return r;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Beats accepted since the current decode started (sampled on the active edge).
  int beats_m = 0;
  initial forever begin
    @(posedge clk);
    if (!rst_n || !busy) beats_m = 0;
    else if (ch_ready && ch_valid) beats_m++;
  end

  int              cyc_m = 0, vn_c = 0, cn_c = 0, proto_err = 0, wd = 0;
  bit              busy_prev = 1'b0, post_done = 1'b0;
  logic            conv_at_done;
  logic [IT_W-1:0] iter_at_done;

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      check("reset_outputs",
            {ch_ready, ch_addr, vn_en, vn_addr, cn_en, cn_addr, busy, done, converged, iter_cnt}, 0);
      busy_prev = 1'b0;
      post_done = 1'b0;
      wd        = 0;
    end else begin
      if (post_done) begin
        check("busy_after_done", busy, 0);
        check("held_result", {converged, iter_cnt}, {conv_at_done, iter_at_done});
        post_done = 1'b0;
      end
      if (busy && !busy_prev) begin
        cyc_m = 1; vn_c = 0; cn_c = 0; proto_err = 0;
      end else if (busy) begin
        cyc_m++;
      end
      busy_prev = busy;

      if (int'(ch_ready) + int'(vn_en) + int'(cn_en) > 1) proto_err++;
      if (!ch_ready && ch_addr != '0) proto_err++;
      if (!vn_en && vn_addr != '0) proto_err++;
      if (!cn_en && cn_addr != '0) proto_err++;
      if (ch_ready && int'(ch_addr) != beats_m % N_VN) proto_err++;
      if (vn_en) begin
        if (int'(vn_addr) != vn_c % N_VN) proto_err++;
        vn_c++;
      end
      if (cn_en) begin
        if (int'(cn_addr) != cn_c % N_CN) proto_err++;
        cn_c++;
      end

      if (done) begin
        check("pending_txn_at_done", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("converged", converged, e.conv);
          check("iter_cnt", iter_cnt, e.iters);
          check("done_cycle", cyc_m, e.lat);
          check("vn_en_cycles", vn_c, e.vn);
          check("cn_en_cycles", cn_c, e.cn);
          check("addr_protocol", proto_err, 0);
        end
        post_done    = 1'b1;
        conv_at_done = converged;
        iter_at_done = iter_cnt;
        wd           = 0;
      end else if (exp_q.size() != 0) begin
        wd++;
        if (wd > WDOG) begin
          checks++;
          errors++;
          $display("FAIL done_timeout: waited %0d cycles, limit %0d", wd, WDOG);
          void'(exp_q.pop_front());
          wd = 0;
        end
      end
    end
  end

  task automatic clear_plan();
    for (int i = 0; i < 16; i++) masks[i] = '0;
    for (int i = 0; i < int'(N_VN); i++) gaps[i] = 0;
  endtask

  // Called on a negedge; returns on a negedge (in DONE if b2b_next, else in IDLE).
  task automatic run_txn(input int mi, input bit poke_done, input bit b2b_next);
    exp_t e;
    int   gsum = 0, cyc = 0, beat = 0, gapleft, it = 0;
    bit   fin = 1'b0;
    for (int i = 0; i < int'(N_VN); i++) gsum += gaps[i];
    e = model(mi, gsum);
    exp_q.push_back(e);
    max_iter = IT_W'(mi);
    start    = 1'b1;
    while (!ch_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    start   = 1'b0;
    gapleft = gaps[0];
    while (!fin && cyc < 800) begin
      if (ch_ready) begin
        if (gapleft > 0) begin
          ch_valid = 1'b0;
          gapleft--;
        end else begin
          ch_valid = 1'b1;
          beat++;
          gapleft = (beat < int'(N_VN)) ? gaps[beat] : 0;
        end
      end else begin
        ch_valid = 1'b0;
      end
      synd_bit = (cn_en && it < 16) ? masks[it][cn_addr] : 1'b0;
      if (cn_en && cn_addr == CN_AW'(N_CN - 1)) it++;
      start = (cn_en && $urandom_range(0, 5) == 0) || (done && poke_done);
      if (done) fin = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!b2b_next) begin
      @(negedge clk);
      start = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    int n;
    clear_plan();
    repeat (3) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // Abort in the middle of the vr sweep.
    max_iter = 4'd2;
    start    = 1'b1;
    n = 0;
    while (!ch_ready && n < 20) begin @(negedge clk); n++; end
    start = 1'b0;
    n = 0;
    while (!(vn_en && vn_addr == 4'd5) && n < 60) begin
      ch_valid = ch_ready;
      @(negedge clk);
      n++;
    end
    @(posedge clk); #2 rst_n = 1'b0;
    ch_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);

    // Converges in the first iteration.
    clear_plan();
    run_txn(5, 1'b0, 1'b0);

    // Check 7 fails every iteration: runs to the cap of 3.
    clear_plan();
    for (int i = 0; i < 16; i++) masks[i] = 8'h80;
    run_txn(3, 1'b0, 1'b0);

    // Zero cap behaves as one iteration.
    clear_plan();
    masks[0] = 8'h01;
    run_txn(0, 1'b0, 1'b0);

    // Alternating valid/gap during load; start poked in DONE then held into IDLE.
    clear_plan();
    masks[0] = 8'h10;
    for (int b = 1; b < int'(N_VN); b++) gaps[b] = 1;
    run_txn(2, 1'b1, 1'b1);

    for (int t = 0; t < 20; t++) begin
      clear_plan();
      for (int i = 0; i < 16; i++)
        masks[i] = ($urandom_range(0, 3) == 0) ? '0 : N_CN'($urandom_range(1, 255));
      for (int b = 0; b < int'(N_VN); b++)
        gaps[b] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      run_txn(int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
              (t != 19) && ($urandom_range(0, 2) == 0));
    end

    n = 0;
    while (exp_q.size() != 0 && n < WDOG + 50) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
